instruction_fetch: RTL

Front-end fetch stage that sits directly upstream of instruction decode. It owns the program counter and issues in-order word requests to instruction memory. It buffers returned instructions with their PCs and hands them to decode over a valid/ready handshake. A single-cycle redirect input (branch, jump, or exception target) flushes buffered and in-flight fetches and restarts fetch at the new PC.

---
 rtl/instruction_fetch_pkg.sv | 13 +
 rtl/instruction_fetch_fetch_queue.sv | 60 ++++++
 rtl/instruction_fetch.sv | 132 +++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   RESET_VECTOR : default first fetch address after reset
//   FetchPacket  : {pc, instruction} entry held in the fetch buffer
package instruction_fetch_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } FetchPacket;

endpackage

// File: rtl/instruction_fetch_fetch_queue.sv
// Synchronous FIFO used for both the pending-PC queue and the fetch buffer.
// Ports:
//   i_clk, i_reset         : clock, synchronous active-high reset
//   i_flush                : empties the queue on the next edge
//   i_push, i_push_data    : write side
//   i_pop, o_head          : read side; o_head is the oldest entry
//   o_full, o_empty, o_count : occupancy status (registered)
module fetch_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  // A push into a full queue is only accepted when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues in-order word requests to instruction
// memory, buffers returned words with their PCs and hands them to decode.
// A redirect flushes buffered packets and discards in-flight responses.
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   imem_req_valid/ready/addr          : request channel to instruction memory
//   imem_resp_valid/data               : in-order response channel (no backpressure)
//   redirect_valid/pc                  : flush and restart fetch at redirect_pc
//   if_valid/ready/pc/instruction      : packet handshake to decode
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_kill_count;

  logic [CW-1:0] w_pend_count;
  logic [CW-1:0] w_buf_count;
  logic          w_pend_full;
  logic          w_pend_empty;
  logic          w_buf_full;
  logic          w_buf_empty;
  logic [31:0]   w_pend_pc;
  FetchPacket    w_buf_push_pkt;
  FetchPacket    w_buf_head;
  logic [CW:0]   w_in_use;
  logic [CW-1:0] w_owed;
  logic          w_req_fire;
  logic          w_resp_pop;
  logic          w_resp_keep;
  logic          w_if_fire;

  // Credit: outstanding requests plus buffered packets never exceed DEPTH,
  // so every response is guaranteed a buffer slot.
  assign w_in_use       = {1'b0, w_pend_count} + {1'b0, w_buf_count};
  assign imem_req_valid = !reset && !redirect_valid && !w_pend_full && !w_buf_full
                          && (w_in_use < (CW+1)'(DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // Every response retires one pending PC; it is kept only when nothing is
  // left to kill and no redirect is flushing this cycle.
  assign w_resp_pop  = imem_resp_valid && !w_pend_empty;
  assign w_resp_keep = w_resp_pop && (r_kill_count == '0) && !redirect_valid;

  // Responses still owed after this cycle; no request can be accepted in a
  // redirect cycle, so only the arriving response is subtracted.
  assign w_owed = w_pend_count - CW'(w_resp_pop);

  assign if_valid       = !w_buf_empty;
  assign w_if_fire      = if_valid && if_ready;
  assign if_pc          = if_valid ? w_buf_head.pc : '0;
  assign if_instruction = if_valid ? w_buf_head.instruction : '0;

  always_comb begin
    w_buf_push_pkt             = '0;
    w_buf_push_pkt.pc          = w_pend_pc;
    w_buf_push_pkt.instruction = imem_resp_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= {RESET_PC[31:2], 2'b00};
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
    end else if (w_req_fire) begin
      r_fetch_pc <= r_fetch_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_kill_count <= '0;
    end else if (redirect_valid) begin
      r_kill_count <= w_owed;
    end else if (w_resp_pop && (r_kill_count != '0)) begin
      r_kill_count <= r_kill_count - CW'(1);
    end
  end

  fetch_queue #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_pending (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_flush     (1'b0),
    .i_push      (w_req_fire),
    .i_push_data (r_fetch_pc),
    .i_pop       (w_resp_pop),
    .o_head      (w_pend_pc),
    .o_full      (w_pend_full),
    .o_empty     (w_pend_empty),
    .o_count     (w_pend_count)
  );

  fetch_queue #(
    .WIDTH ($bits(FetchPacket)),
    .DEPTH (DEPTH)
  ) u_buffer (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_flush     (redirect_valid),
    .i_push      (w_resp_keep),
    .i_push_data (w_buf_push_pkt),
    .i_pop       (w_if_fire),
    .o_head      (w_buf_head),
    .o_full      (w_buf_full),
    .o_empty     (w_buf_empty),
    .o_count     (w_buf_count)
  );

endmodule
